add_float: RTL and testbench

Multi-cycle IEEE-754 binary floating-point adder/subtractor with a start/done handshake. It accepts two operands and an add/subtract select, and computes the correctly rounded sum or difference using round-to-nearest-even. It returns the result with NaN, overflow, underflow and zero status flags. The block sits in the neural-net datapath as the shared FP accumulate unit.

---
 rtl/add_float.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_add_float.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/add_float.sv
// add_float: multi-cycle IEEE-754 adder/subtractor with round-to-nearest-even.
// Subnormal operands are flushed to zero; results below the normal range flush to zero.
// Pipeline of states IDLE -> ALIGN -> ADD -> NORM -> ROUND, one state per clock.
module add_float #(
    parameter int FLOAT_WIDTH = 32
) (
    input  logic                   rst_n,
    input  logic                   clk,
    input  logic                   start,
    input  logic                   sub,
    input  logic [FLOAT_WIDTH-1:0] a,
    input  logic [FLOAT_WIDTH-1:0] b,
    output logic [FLOAT_WIDTH-1:0] o,
    output logic                   nan,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   zero,
    output logic                   done
);
    localparam int FW = FLOAT_WIDTH;
    localparam int EW = (FW == 16) ? 5 : (FW == 64) ? 11 : 8;
    localparam int MW = FW - EW - 1;   // stored fraction bits
    localparam int SW = MW + 4;        // hidden + fraction + guard/round/sticky
    localparam int XW = EW + 2;        // signed working exponent, room for carries and underflow
    localparam logic [EW-1:0] EMAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spc_t;

    state_t state_q, state_d;
    logic   cap;
    logic   done_d;

    // ------------------------------------------------------------------
    // Unpack
    // ------------------------------------------------------------------
    logic          sa, sb;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic          a_nan, b_nan, a_inf, b_inf, a_zr, b_zr;
    spc_t          sp_d;
    logic          sps_d;

    assign sa    = a[FW-1];
    assign sb    = b[FW-1] ^ sub;   // effective sign of b
    assign ea    = a[FW-2:MW];
    assign eb    = b[FW-2:MW];
    assign fa    = a[MW-1:0];
    assign fb    = b[MW-1:0];
    assign a_nan = (&ea) & (|fa);
    assign b_nan = (&eb) & (|fb);
    assign a_inf = (&ea) & ~(|fa);
    assign b_inf = (&eb) & ~(|fb);
    assign a_zr  = ~(|ea);          // zero or subnormal, both treated as zero
    assign b_zr  = ~(|eb);

    // Classify operand combinations whose result bypasses the datapath
    always_comb begin
        sp_d  = SP_NONE;
        sps_d = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sp_d = SP_NAN;
        end else if (a_inf || b_inf) begin
            sp_d  = SP_INF;
            sps_d = a_inf ? sa : sb;
        end else if (a_zr && b_zr) begin
            // both zero: negative only when both effective signs are negative
            sp_d  = SP_ZERO;
            sps_d = sa & sb;
        end
    end

    logic          sa_q, sb_q, sps_q;
    logic [EW-1:0] ea_q, eb_q;
    logic [MW:0]   ma_q, mb_q;
    spc_t          sp_q;

    // Capture unpacked operands on the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ea_q  <= '0;
            eb_q  <= '0;
            ma_q  <= '0;
            mb_q  <= '0;
            sp_q  <= SP_NONE;
            sps_q <= 1'b0;
        end else if (cap) begin
            sa_q  <= sa;
            sb_q  <= sb;
            ea_q  <= ea;
            eb_q  <= eb;
            ma_q  <= a_zr ? '0 : {1'b1, fa};
            mb_q  <= b_zr ? '0 : {1'b1, fb};
            sp_q  <= sp_d;
            sps_q <= sps_d;
        end
    end

    // ------------------------------------------------------------------
    // Align
    // ------------------------------------------------------------------
    logic            a_big, sl;
    logic [EW-1:0]   el, es, dexp, sh;
    logic [MW:0]     ml, msm;
    logic [2*SW-1:0] wide;
    logic [SW-1:0]   ms_al;

    // Order by magnitude, then shift the smaller significand right, folding lost bits into sticky
    always_comb begin
        a_big = {ea_q, ma_q} >= {eb_q, mb_q};
        el    = a_big ? ea_q : eb_q;
        es    = a_big ? eb_q : ea_q;
        ml    = a_big ? ma_q : mb_q;
        msm   = a_big ? mb_q : ma_q;
        sl    = a_big ? sa_q : sb_q;
        dexp  = el - es;
        sh    = (dexp > EW'(SW)) ? EW'(SW) : dexp;
        wide  = {msm, 3'b000, {SW{1'b0}}} >> sh;
        ms_al = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
    end

    logic                 sgn_q, esub_q;
    logic signed [XW-1:0] exp_q;
    logic [SW-1:0]        ml_q, ms_q;

    // Register aligned operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q  <= 1'b0;
            esub_q <= 1'b0;
            exp_q  <= '0;
            ml_q   <= '0;
            ms_q   <= '0;
        end else if (state_q == S_ALIGN) begin
            sgn_q  <= sl;
            esub_q <= sa_q ^ sb_q;
            exp_q  <= $signed({2'b00, el});
            ml_q   <= {ml, 3'b000};
            ms_q   <= ms_al;
        end
    end

    // ------------------------------------------------------------------
    // Add / subtract magnitudes (larger first, so the difference is never negative)
    // ------------------------------------------------------------------
    logic [SW:0] sum_q;

    // Register the raw significand sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (state_q == S_ADD) begin
            sum_q <= esub_q ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});
        end
    end

    // ------------------------------------------------------------------
    // Normalize
    // ------------------------------------------------------------------
    function automatic logic [7:0] lzc(input logic [SW-1:0] v);
        lzc = 8'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) lzc = 8'(SW - 1 - i);
        end
    endfunction

    logic [7:0]           lz;
    logic [SW-1:0]        nrm_d;
    logic signed [XW-1:0] nexp_d;

    // Bring the leading one to the hidden-bit position
    always_comb begin
        lz = lzc(sum_q[SW-1:0]);
        if (sum_q[SW]) begin
            nrm_d  = {sum_q[SW:2], sum_q[1] | sum_q[0]};
            nexp_d = exp_q + XW'(1);
        end else begin
            nrm_d  = sum_q[SW-1:0] << lz;
            nexp_d = exp_q - XW'(lz);
        end
    end

    logic [SW-1:0]        nrm_q;
    logic signed [XW-1:0] nexp_q;
    logic                 cz_q;

    // Register normalized significand; cz_q marks exact cancellation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrm_q  <= '0;
            nexp_q <= '0;
            cz_q   <= 1'b0;
        end else if (state_q == S_NORM) begin
            nrm_q  <= nrm_d;
            nexp_q <= nexp_d;
            cz_q   <= ~(|sum_q);
        end
    end

    // ------------------------------------------------------------------
    // Round and pack
    // ------------------------------------------------------------------
    logic                 rinc;
    logic [MW+1:0]        mant;
    logic signed [XW-1:0] rexp;
    logic [MW-1:0]        rfrac;
    logic [FW-1:0]        o_d;
    logic                 nan_d, ovf_d, unf_d, zero_d;

    // Round to nearest even, then select special, overflow, underflow or normal packing
    always_comb begin
        rinc   = nrm_q[2] & (nrm_q[3] | nrm_q[1] | nrm_q[0]);
        mant   = {1'b0, nrm_q[SW-1:3]} + (MW+2)'(rinc);
        rexp   = nexp_q;
        rfrac  = mant[MW-1:0];
        if (mant[MW+1]) begin
            rexp  = nexp_q + XW'(1);
            rfrac = mant[MW:1];
        end
        o_d    = '0;
        nan_d  = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        zero_d = 1'b0;
        case (sp_q)
            SP_NAN: begin
                o_d   = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
                nan_d = 1'b1;
            end
            SP_INF: begin
                o_d = {sps_q, EMAX, {MW{1'b0}}};
            end
            SP_ZERO: begin
                o_d    = {sps_q, {(FW-1){1'b0}}};
                zero_d = 1'b1;
            end
            default: begin
                if (cz_q) begin
                    o_d    = '0;
                    zero_d = 1'b1;
                end else if (rexp >= $signed({2'b00, EMAX})) begin
                    o_d   = {sgn_q, EMAX, {MW{1'b0}}};
                    ovf_d = 1'b1;
                end else if (rexp <= 0) begin
                    o_d    = {sgn_q, {(FW-1){1'b0}}};
                    unf_d  = 1'b1;
                    zero_d = 1'b1;
                end else begin
                    o_d = {sgn_q, rexp[EW-1:0], rfrac};
                end
            end
        endcase
    end

    // Result and flags update only on the ROUND edge and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o         <= '0;
            nan       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_d;
            if (done_d) begin
                o         <= o_d;
                nan       <= nan_d;
                overflow  <= ovf_d;
                underflow <= unf_d;
                zero      <= zero_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: fixed walk through the stages, start only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs: operand capture and result commit strobes
    always_comb begin
        cap    = (state_q == S_IDLE) && start;
        done_d = (state_q == S_ROUND);
    end

endmodule

// File: tb/tb_add_float.sv
// tb_add_float: scoreboard bench for add_float (FP32), directed vectors with known results.
module tb_add_float;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] o;
    logic        nan, overflow, underflow, zero, done;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_done = 0;
    logic done_prev = 1'b0;

    logic [35:0] exp_q[$];
    string       tag_q[$];
    int          cap_q[$];

    string       mon_tag;
    logic [35:0] mon_exp;
    int          mon_cap;

    add_float #(.FLOAT_WIDTH(32)) dut (
        .rst_n(rst_n), .clk(clk), .start(start), .sub(sub), .a(a), .b(b),
        .o(o), .nan(nan), .overflow(overflow), .underflow(underflow),
        .zero(zero), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    // flags ordered {nan, overflow, underflow, zero}
    function automatic logic [35:0] res(input logic [31:0] v, input logic [3:0] f);
        return {v, f};
    endfunction

    // Scoreboard: every done must match the oldest pending expectation, 4 cycles after capture
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            chk("done_pulse", 36'(done_prev), 36'd0);
            chk("pending", 36'(exp_q.size() != 0), 36'd1);
            if (exp_q.size() != 0) begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                mon_cap = cap_q.pop_front();
                chk({mon_tag, "_lat"}, 36'(cyc - mon_cap), 36'd4);
                chk(mon_tag, {o, nan, overflow, underflow, zero}, mon_exp);
            end
        end
        done_prev = done;
    end

    task automatic run(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic isub, input logic [35:0] want);
        int nd;
        @(posedge clk); #1;
        a = ia; b = ib; sub = isub; start = 1'b1;
        exp_q.push_back(want); tag_q.push_back(tag); cap_q.push_back(cyc + 1);
        nd = n_done;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        for (int i = 0; i < 10 && n_done == nd; i++) @(posedge clk);
        chk({tag, "_seen"}, 36'(n_done != nd), 36'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nd;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {o, nan, overflow, underflow, zero}, 36'd0);
        chk("rst_done", 36'(done), 36'd0);
        rst_n = 1'b1;

        run("add5",     32'h40A00000, 32'h40A00000, 1'b0, res(32'h41200000, 4'b0000));
        run("sub3m1",   32'h40400000, 32'h3F800000, 1'b1, res(32'h40000000, 4'b0000));
        run("cancel",   32'h3F800000, 32'hBF800000, 1'b0, res(32'h00000000, 4'b0001));
        run("cancel_s", 32'h40400000, 32'h40400000, 1'b1, res(32'h00000000, 4'b0001));
        run("tie_even", 32'h3F800000, 32'h33800000, 1'b0, res(32'h3F800000, 4'b0000));
        run("ulp_up",   32'h3F800000, 32'h34000000, 1'b0, res(32'h3F800001, 4'b0000));
        run("rnd_carry",32'h3FFFFFFF, 32'h33800000, 1'b0, res(32'h40000000, 4'b0000));
        run("one_m",    32'h3F800000, 32'h33800000, 1'b1, res(32'h3F7FFFFF, 4'b0000));
        run("far_shift",32'h3F800000, 32'h30800000, 1'b0, res(32'h3F800000, 4'b0000));
        run("mixed",    32'h3FC00000, 32'h40200000, 1'b0, res(32'h40800000, 4'b0000));
        run("neg_sub",  32'hBFC00000, 32'h40200000, 1'b1, res(32'hC0800000, 4'b0000));
        run("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, res(32'h7F800000, 4'b0100));
        run("inf_nan",  32'h7F800000, 32'hFF800000, 1'b0, res(32'h7FC00000, 4'b1000));
        run("inf_nan_s",32'h7F800000, 32'h7F800000, 1'b1, res(32'h7FC00000, 4'b1000));
        run("inf_pass", 32'h7F800000, 32'h3F800000, 1'b0, res(32'h7F800000, 4'b0000));
        run("ninf",     32'hFF800000, 32'h3F800000, 1'b0, res(32'hFF800000, 4'b0000));
        run("nan_in",   32'h7FC00001, 32'h3F800000, 1'b0, res(32'h7FC00000, 4'b1000));
        run("unf",      32'h00800001, 32'h80800000, 1'b0, res(32'h00000000, 4'b0011));
        run("subn_ftz", 32'h00000001, 32'h3F800000, 1'b0, res(32'h3F800000, 4'b0000));
        run("nz_m_pz",  32'h80000000, 32'h00000000, 1'b1, res(32'h80000000, 4'b0001));
        run("pz_p_nz",  32'h00000000, 32'h80000000, 1'b0, res(32'h00000000, 4'b0001));
        run("nz_p_nz",  32'h80000000, 32'h80000000, 1'b0, res(32'h80000000, 4'b0001));

        // result holds after done
        repeat (3) @(posedge clk);
        #1;
        chk("hold", {o, nan, overflow, underflow, zero}, res(32'h80000000, 4'b0001));

        // start held high while busy: only one operation
        @(posedge clk); #1;
        a = 32'h40A00000; b = 32'h40A00000; sub = 1'b0; start = 1'b1;
        exp_q.push_back(res(32'h41200000, 4'b0000)); tag_q.push_back("busy"); cap_q.push_back(cyc + 1);
        nd = n_done;
        repeat (4) begin
            @(posedge clk); #1;
            a = 32'h3F800000; b = 32'h3F800000;
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        chk("busy_one_done", 36'(n_done - nd), 36'd1);

        // leave a nonzero result, then abort an operation in NORM
        run("pre_rst", 32'h40400000, 32'h3F800000, 1'b1, res(32'h40000000, 4'b0000));
        @(posedge clk); #1;
        a = 32'h40A00000; b = 32'h40A00000; sub = 1'b0; start = 1'b1;
        nd = n_done;
        @(posedge clk); #1;             // captured, now ALIGN
        start = 1'b0;
        @(posedge clk);                 // ADD
        @(posedge clk); #1;             // NORM
        rst_n = 1'b0;
        #2;
        chk("abort_out", {o, nan, overflow, underflow, zero}, 36'd0);
        chk("abort_done", 36'(done), 36'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        chk("abort_no_done", 36'(n_done - nd), 36'd0);

        run("post_rst", 32'h3FC00000, 32'h40200000, 1'b0, res(32'h40800000, 4'b0000));
        repeat (2) @(posedge clk);
        chk("queue_empty", 36'(exp_q.size()), 36'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
